bus_arbiter: RTL

Two-master, single-slave arbiter on the SoC's shared memory bus. Masters: debugger (M0) and CPU (M1); slave: the OR-combined RAM/ROM/MMIO decode. Replaces the combinational `dbg_mem_op ? … : …` mux with a registered, handshaked arbiter. No master can corrupt the other's access. CPU cannot starve under sustained debugger traffic.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_pick.sv | 25 ++
 rtl/bus_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM state codes and
// bus owner identifiers.
package bus_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_ACCESS = 2'd1;
   localparam logic [1:0] ARB_RESP   = 2'd2;

   localparam logic OWN_DBG = 1'b0;
   localparam logic OWN_CPU = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = ARB_IDLE,
      S_ACCESS = ARB_ACCESS,
      S_RESP   = ARB_RESP
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational winner select between debugger (M0) and CPU (M1) requests,
// either fixed M0 priority or round-robin against the previous owner.
module arb_pick
   import bus_arbiter_pkg::*;
#(
   parameter int RR = 1
) (
   input  logic r0,
   input  logic r1,
   input  logic last_owner,
   output logic grant,
   output logic winner
);

   always_comb begin
      grant  = r0 | r1;
      winner = OWN_DBG;
      if (r0 && r1) begin
         winner = (RR != 0) ? ~last_owner : OWN_DBG;
      end else if (r1) begin
         winner = OWN_CPU;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Registered, handshaked arbiter granting one of two masters access to the
// shared memory bus: one bus_op strobe per transaction, rdy one cycle later.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADR_W  = 32,
   parameter int DATA_W = 32,
   parameter int RR     = 1
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  m0_req,
   input  logic                  m1_req,
   input  logic [ADR_W-1:0]      m0_adr,
   input  logic [ADR_W-1:0]      m1_adr,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m0_wren,
   input  logic [DATA_W/8-1:0]   m1_wren,
   output logic                  m0_rdy,
   output logic                  m1_rdy,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [DATA_W-1:0]     m1_rdata,
   input  logic                  cpu_en,
   output logic                  bus_op,
   output logic [ADR_W-1:0]      bus_adr,
   output logic [DATA_W-1:0]     bus_wdata,
   output logic [DATA_W/8-1:0]   bus_wren,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  bus_owner
);

   arb_state_t state, state_nxt;
   logic       last_owner;
   logic       r0, r1;
   logic       pick_r0, pick_r1;
   logic       pick_grant, pick_winner;
   logic       load;

   assign r0 = m0_req;
   assign r1 = m1_req & cpu_en;

   // In RESP the current owner's req is still high; mask it so only the
   // other master can be chained straight into the next ACCESS.
   assign pick_r0 = r0 & ~((state == S_RESP) && (bus_owner == OWN_DBG));
   assign pick_r1 = r1 & ~((state == S_RESP) && (bus_owner == OWN_CPU));

   arb_pick #(.RR(RR)) u_pick (
      .r0         (pick_r0),
      .r1         (pick_r1),
      .last_owner (last_owner),
      .grant      (pick_grant),
      .winner     (pick_winner)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick_grant) begin
               state_nxt = S_ACCESS;
               load      = 1'b1;
            end
         end
         S_ACCESS: state_nxt = S_RESP;
         S_RESP: begin
            if (pick_grant) begin
               state_nxt = S_ACCESS;
               load      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state      <= S_IDLE;
         bus_adr    <= '0;
         bus_wdata  <= '0;
         bus_wren   <= '0;
         bus_owner  <= OWN_DBG;
         last_owner <= OWN_CPU;
      end else begin
         state <= state_nxt;
         if (load) begin
            bus_adr    <= (pick_winner == OWN_CPU) ? m1_adr   : m0_adr;
            bus_wdata  <= (pick_winner == OWN_CPU) ? m1_wdata : m0_wdata;
            bus_wren   <= (pick_winner == OWN_CPU) ? m1_wren  : m0_wren;
            bus_owner  <= pick_winner;
            last_owner <= pick_winner;
         end
      end
   end

   assign bus_op   = (state == S_ACCESS);
   assign m0_rdy   = (state == S_RESP) && (bus_owner == OWN_DBG);
   assign m1_rdy   = (state == S_RESP) && (bus_owner == OWN_CPU);
   assign m0_rdata = m0_rdy ? bus_rdata : '0;
   assign m1_rdata = m1_rdy ? bus_rdata : '0;

endmodule
